acl_filter: RTL and testbench

Sits between `spi_master` and the display consumers (`vga`, `seg7_control`, LEDs) on the 100 MHz domain. Takes the raw 15-bit packed accelerometer word and resynchronises it from the 4 MHz SPI domain. Samples it at a fixed rate and outputs a per-axis boxcar (moving) average over the last 2^DEPTH_LOG2 samples, which stops display flicker. The output keeps the same packing as the input, so it drops in wherever `acl_data` is consumed today.

---
 rtl/acl_filter.sv | 136 +++++++++++++
 tb/tb_acl_filter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acl_filter.sv
// acl_filter: resynchronises the packed 3-axis accelerometer word and emits a
// per-axis boxcar average over the last 2**DEPTH_LOG2 samples at a fixed rate.
module acl_filter #(
    parameter int SAMPLE_DIV = 100000,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [14:0] acl_data,
    output logic [14:0] filt_data,
    output logic        filt_valid,
    output logic        primed,
    output logic [0:0]  dbg_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(SAMPLE_DIV);
    localparam int SW    = 5 + DEPTH_LOG2;

    localparam logic [CW-1:0]         DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]         DIV_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [14:0]           s1_q, s2_q, s3_q;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  pending_q, pending_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] fill_cnt_q, fill_cnt_d;
    logic [0:0]            state_q, state_d;

    logic signed [4:0]     buf_q    [3][DEPTH];
    logic signed [SW-1:0]  sum_q    [3];
    logic signed [SW-1:0]  sum_d    [3];
    logic signed [SW-1:0]  avg_full [3];
    logic signed [4:0]     new_v    [3];
    logic signed [4:0]     old_v    [3];

    logic [14:0]           filt_data_q, filt_data_d;
    logic                  filt_valid_q;

    logic                  tick;
    logic                  stable;
    logic                  capture;

    // filt_valid is a one-cycle strobe with no backpressure: consumers must
    // take filt_data on the cycle it is high; filt_data then holds until the next strobe.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        stable    = (s2_q == s3_q);
        capture   = (pending_q | tick) & stable;
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;

        pending_d = pending_q;
        if (capture) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end

        wr_ptr_d = capture ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    end

    // Axis a occupies bits [a*5 +: 5]: a=0 is Z, a=1 is Y, a=2 is X.
    always_comb begin
        filt_data_d = '0;
        for (int a = 0; a < 3; a++) begin
            new_v[a]    = s2_q[a*5 +: 5];
            old_v[a]    = buf_q[a][wr_ptr_q];
            sum_d[a]    = sum_q[a]
                        + $signed({{(SW-5){new_v[a][4]}}, new_v[a]})
                        - $signed({{(SW-5){old_v[a][4]}}, old_v[a]});
            avg_full[a] = sum_d[a] >>> DEPTH_LOG2;
            filt_data_d[a*5 +: 5] = avg_full[a][4:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (capture && (state_q == ST_FILL)) begin
            if (fill_cnt_q == PTR_LAST) begin
                state_d = ST_RUN;
            end else begin
                fill_cnt_d = fill_cnt_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            div_cnt_q    <= '0;
            pending_q    <= 1'b0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            state_q      <= ST_FILL;
            filt_data_q  <= '0;
            filt_valid_q <= 1'b0;
            for (int a = 0; a < 3; a++) begin
                sum_q[a] <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    buf_q[a][k] <= '0;
                end
            end
        end else begin
            s1_q         <= acl_data;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            div_cnt_q    <= div_cnt_d;
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            state_q      <= state_d;
            filt_valid_q <= capture;
            if (capture) begin
                filt_data_q <= filt_data_d;
                for (int a = 0; a < 3; a++) begin
                    sum_q[a]              <= sum_d[a];
                    buf_q[a][wr_ptr_q]    <= new_v[a];
                end
            end
        end
    end

    assign filt_data   = filt_data_q;
    assign filt_valid  = filt_valid_q;
    assign primed      = (state_q == ST_RUN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acl_filter.sv
// Bench for acl_filter: drives sample words aligned to the divider phase and
// scores every filt_valid pulse against a window model held in exp_q.
module tb_acl_filter;

    localparam int SDIV  = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    localparam logic [14:0] FILL_W = {5'd12, 5'b11100, 5'd15};
    localparam logic [14:0] ROLL_W = {5'd0,  5'b11100, 5'd15};

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] acl_data;
    logic [14:0] filt_data;
    logic        filt_valid;
    logic        primed;
    logic [0:0]  dbg_state;

    acl_filter #(
        .SAMPLE_DIV (SDIV),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .acl_data    (acl_data),
        .filt_data   (filt_data),
        .filt_valid  (filt_valid),
        .primed      (primed),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [15:0] exp_q[$];
    int          mbuf[3][DEPTH];
    int          mptr;
    int          mfill;

    task automatic model_reset();
        for (int a = 0; a < 3; a++)
            for (int k = 0; k < DEPTH; k++)
                mbuf[a][k] = 0;
        mptr  = 0;
        mfill = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [14:0] w);
        logic [14:0]       res;
        logic signed [4:0] f;
        int                s;
        logic [31:0]       q;
        for (int a = 0; a < 3; a++) begin
            f = w[a*5 +: 5];
            mbuf[a][mptr] = int'(f);
        end
        mptr  = (mptr + 1) % DEPTH;
        mfill = mfill + 1;
        res   = '0;
        for (int a = 0; a < 3; a++) begin
            s = 0;
            for (int k = 0; k < DEPTH; k++) s = s + mbuf[a][k];
            q = s >>> DL2;
            res[a*5 +: 5] = q[4:0];
        end
        exp_q.push_back({(mfill >= DEPTH) ? 1'b1 : 1'b0, res});
    endtask

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (filt_valid) begin
                chk("pulse_gap", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("filt_word", {16'd0, primed, filt_data}, {16'd0, e});
                end
            end
            prev_valid = filt_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_phase0();
        @(negedge clk);
        while ((cyc % SDIV) != 0) @(negedge clk);
    endtask

    task automatic drive_sample(input logic [14:0] w);
        next_phase0();
        acl_data = w;
        model_push(w);
    endtask

    task automatic unstable_then_hold(input int n, input logic [14:0] w, input string tag);
        int k;
        next_phase0();
        for (int i = 0; i < n; i++) begin
            acl_data = (i % 2 == 1) ? 15'h2AAA : 15'h5555;
            @(negedge clk);
        end
        acl_data = w;
        model_push(w);
        k = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (filt_valid) begin
                k = j;
                break;
            end
        end
        chk(tag, k, 4);
        // the following tick recaptures the word still being held
        model_push(w);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset    = 1'b1;
        acl_data = 15'h7FFF;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_outs", {15'd0, filt_valid, primed, filt_data}, 32'd0);
        end
        chk("reset_state", {31'd0, dbg_state}, 32'd0);

        reset = 1'b0;
        model_push(15'h7FFF);
        n = 0;
        for (int k = 1; k <= SDIV + 3; k++) begin
            @(negedge clk);
            if (filt_valid) begin
                n = k;
                break;
            end
        end
        chk("first_valid_lat", {31'd0, (n >= 1 && n <= SDIV + 3)}, 32'd1);

        @(negedge clk);
        reset    = 1'b1;
        acl_data = FILL_W;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // signed fill: X 3,6,9,12  Y -1,-2,-3,-4  Z 3,7,11,15
        model_push(FILL_W);
        for (int i = 0; i < DEPTH - 1; i++) drive_sample(FILL_W);
        // window roll-off: X 9,6,3,0
        for (int i = 0; i < DEPTH; i++) drive_sample(ROLL_W);
        chk("state_run", {31'd0, dbg_state}, 32'd1);

        unstable_then_hold(6,  {5'd4, 10'd0}, "settle_lat_one_tick");
        unstable_then_hold(10, {5'b11010, 5'd3, 5'd0}, "settle_lat_missed_tick");

        for (int i = 0; i < 3; i++) drive_sample(15'($urandom_range(0, 32767)));
        drive_sample(FILL_W);
        drive_sample(FILL_W);

        // reset asynchronously in the cycle whose closing edge would capture
        @(negedge clk);
        while ((cyc % SDIV) != SDIV - 1) @(negedge clk);
        chk("primed_before_reset", {31'd0, primed}, 32'd1);
        chk("data_nonzero_before_reset", {31'd0, (filt_data != 15'd0)}, 32'd1);
        reset    = 1'b1;
        acl_data = FILL_W;
        model_reset();
        #1;
        chk("async_clear", {15'd0, filt_valid, primed, filt_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        model_push(FILL_W);
        for (int i = 0; i < DEPTH - 1; i++) drive_sample(FILL_W);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
